// File: rtl/cpu_debug_scan_bridge.sv
// Virtual-JTAG data-register bridge, oversampled in the system clock domain.
// Delivers accepted scan words on jdo with one-hot action pulses and flags bad scan lengths.
module cpu_debug_scan_bridge #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 35
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         tck,
  input  logic                         tdi,
  input  logic                         vs_cdr,
  input  logic                         vs_sdr,
  input  logic                         vs_udr,
  input  logic                         vs_uir,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [SR_W*(2**IR_W)-1:0]    capture_data,
  input  logic                         err_clr,
  output logic                         tdo,
  output logic [SR_W-1:0]              jdo,
  output logic [IR_W-1:0]              ir_latched,
  output logic [(2**IR_W)-1:0]         take_action,
  output logic [(2**IR_W)-1:0]         take_no_action,
  output logic                         len_err
);

  localparam int NCH   = 2**IR_W;
  localparam int CNT_W = $clog2(SR_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SR_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SR_W + 1);

  logic [5:0]      sync_q [SYNC_STAGES];
  logic [IR_W-1:0] ir_sync_q [SYNC_STAGES];
  logic [2:0]      edge_q;

  logic            tck_s, tdi_s, cdr_s, sdr_s, udr_s, uir_s;
  logic [IR_W-1:0] ir_s;
  logic            tck_rise, udr_rise, uir_rise;

  logic [SR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  cap_word;
  logic             len_set;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i]    <= '0;
        ir_sync_q[i] <= '0;
      end
      edge_q <= '0;
    end else begin
      sync_q[0]    <= {tck, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir};
      ir_sync_q[0] <= ir_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i]    <= sync_q[i-1];
        ir_sync_q[i] <= ir_sync_q[i-1];
      end
      edge_q <= {tck_s, udr_s, uir_s};
    end
  end

  assign {tck_s, tdi_s, cdr_s, sdr_s, udr_s, uir_s} = sync_q[SYNC_STAGES-1];
  assign ir_s     = ir_sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~edge_q[2];
  assign udr_rise = udr_s & ~edge_q[1];
  assign uir_rise = uir_s & ~edge_q[0];

  always_comb begin
    cap_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ir_s == IR_W'(k)) cap_word = capture_data[k*SR_W +: SR_W];
    end
  end

  // A scan is only accepted at exactly SR_W shifts; zero shifts is a legal read-only scan.
  assign len_set = udr_rise && (cnt != '0) && (cnt != CNT_FULL);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr             <= '0;
      cnt            <= '0;
      tdo            <= 1'b0;
      jdo            <= '0;
      ir_latched     <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      len_err        <= 1'b0;
    end else begin
      tdo            <= sr[0];
      take_action    <= '0;
      take_no_action <= '0;
      len_err        <= len_set | (len_err & ~err_clr);
      if (tck_rise) begin
        if (cdr_s) begin
          sr  <= cap_word;
          cnt <= '0;
        end else if (sdr_s) begin
          sr <= {tdi_s, sr[SR_W-1:1]};
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
      end
      if (uir_rise) ir_latched <= ir_s;
      // Update clears the count last so it overrides any shift in the same cycle.
      if (udr_rise) begin
        cnt <= '0;
        if (cnt == CNT_FULL) begin
          jdo <= sr;
          if (sr[ACT_BIT]) take_action[ir_latched]    <= 1'b1;
          else             take_no_action[ir_latched] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_debug_scan_bridge.sv
// Directed self-checking bench for cpu_debug_scan_bridge with default parameters.
// Drives inputs on the falling clk edge and samples outputs away from the rising edge.
module tb_cpu_debug_scan_bridge;

  localparam int SR_W = 38;
  localparam int IR_W = 2;
  localparam int SYNC_STAGES = 2;
  localparam int NCH = 4;

  localparam logic [SR_W-1:0] SLICE0 = 38'h11_0000_0000;
  localparam logic [SR_W-1:0] SLICE1 = 38'h2A_5A5A_5A59;
  localparam logic [SR_W-1:0] SLICE2 = 38'h00_1234_5678;
  localparam logic [SR_W-1:0] SLICE3 = 38'h15_0F0F_0F0F;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tck = 1'b0, tdi = 1'b0;
  logic vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0, vs_uir = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W*NCH-1:0] capture_data;
  logic err_clr = 1'b0;
  logic tdo;
  logic [SR_W-1:0] jdo;
  logic [IR_W-1:0] ir_latched;
  logic [NCH-1:0] take_action, take_no_action;
  logic len_err;

  int checks = 0;
  int errors = 0;

  logic [NCH-1:0]  act_s, nact_s;
  int              n_pulse;
  logic            err_s;
  logic [SR_W-1:0] stream;

  assign capture_data = {SLICE3, SLICE2, SLICE1, SLICE0};

  always #5 clk = ~clk;

  cpu_debug_scan_bridge #(.SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(SYNC_STAGES), .ACT_BIT(35)) dut (
    .clk(clk), .reset_n(reset_n), .tck(tck), .tdi(tdi),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .capture_data(capture_data), .err_clr(err_clr),
    .tdo(tdo), .jdo(jdo), .ir_latched(ir_latched),
    .take_action(take_action), .take_no_action(take_no_action), .len_err(len_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tck_pulse();
    tck = 1'b1;
    wait_neg(4);
    tck = 1'b0;
    wait_neg(4);
  endtask

  task automatic run_uir(input logic [IR_W-1:0] code);
    ir_in  = code;
    vs_uir = 1'b1;
    wait_neg(5);
    vs_uir = 1'b0;
    wait_neg(4);
  endtask

  task automatic capture();
    vs_cdr = 1'b1;
    wait_neg(4);
    tck_pulse();
    vs_cdr = 1'b0;
    wait_neg(4);
  endtask

  // Shifts nbits of word LSB-first, recording tdo before each tck rise.
  task automatic applyStimulus(input logic [SR_W-1:0] word, input int nbits, output logic [SR_W-1:0] tdo_stream);
    tdo_stream = '0;
    vs_sdr = 1'b1;
    wait_neg(4);
    for (int i = 0; i < nbits; i++) begin
      tdi = word[i];
      tdo_stream[i] = tdo;
      tck_pulse();
    end
    vs_sdr = 1'b0;
    tdi    = 1'b0;
    wait_neg(4);
  endtask

  // Raises vs_udr (optionally with vs_uir) and watches 8 clks of pulse outputs.
  task automatic run_udr(input logic with_uir, input int clr_cycle,
                         output logic [NCH-1:0] a, output logic [NCH-1:0] na,
                         output int np, output logic e);
    a = '0; na = '0; np = 0; e = 1'b0;
    vs_udr = 1'b1;
    vs_uir = with_uir;
    for (int c = 1; c <= 8; c++) begin
      err_clr = (c == clr_cycle);
      @(posedge clk);
      #1;
      if ((take_action | take_no_action) != '0) np++;
      if ($countones(take_action | take_no_action) > 1) np += 10;
      if (c == SYNC_STAGES + 1) begin
        a  = take_action;
        na = take_no_action;
        e  = len_err;
      end
      @(negedge clk);
    end
    err_clr = 1'b0;
    vs_udr  = 1'b0;
    vs_uir  = 1'b0;
    wait_neg(4);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    wait_neg(1);
    err_clr = 1'b0;
    wait_neg(1);
  endtask

  initial begin
    // Reset with tck toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tck = ~tck;
    end
    @(negedge clk);
    checkOutput("rst_jdo", jdo, 0);
    checkOutput("rst_ir", ir_latched, 0);
    checkOutput("rst_act", {take_action, take_no_action}, 0);
    checkOutput("rst_err", len_err, 0);
    checkOutput("rst_tdo", tdo, 0);
    tck = 1'b0;
    reset_n = 1'b1;
    wait_neg(6);
    checkOutput("rel_jdo", jdo, 0);
    checkOutput("rel_err", len_err, 0);
    checkOutput("rel_pulse", {take_action, take_no_action}, 0);

    // IR=2 full scan of ones
    run_uir(2'b10);
    checkOutput("ir2", ir_latched, 2);
    capture();
    applyStimulus({SR_W{1'b1}}, SR_W, stream);
    checkOutput("tdo_stream", stream, SLICE2);
    run_udr(1'b0, 0, act_s, nact_s, n_pulse, err_s);
    checkOutput("ir2_act", act_s, 4'b0100);
    checkOutput("ir2_nact", nact_s, 4'b0000);
    checkOutput("ir2_npulse", n_pulse, 1);
    checkOutput("ir2_jdo", jdo, 38'h3F_FFFF_FFFF);

    // IR=1, bit35 clear gives the no-action pulse
    run_uir(2'b01);
    capture();
    applyStimulus(38'h00_ABCD_1234, SR_W, stream);
    run_udr(1'b0, 0, act_s, nact_s, n_pulse, err_s);
    checkOutput("ir1_act", act_s, 4'b0000);
    checkOutput("ir1_nact", nact_s, 4'b0010);
    checkOutput("ir1_npulse", n_pulse, 1);
    checkOutput("ir1_jdo", jdo, 38'h00_ABCD_1234);

    // Short scan raises len_err; err_clr clears; set beats clear
    capture();
    applyStimulus(38'h3F_0000_FFFF, SR_W - 1, stream);
    run_udr(1'b0, 0, act_s, nact_s, n_pulse, err_s);
    checkOutput("short_npulse", n_pulse, 0);
    checkOutput("short_jdo", jdo, 38'h00_ABCD_1234);
    checkOutput("short_err", len_err, 1);
    pulse_err_clr();
    checkOutput("errclr", len_err, 0);
    capture();
    applyStimulus(38'h3F_0000_FFFF, SR_W - 1, stream);
    run_udr(1'b0, SYNC_STAGES + 1, act_s, nact_s, n_pulse, err_s);
    checkOutput("set_vs_clr_now", err_s, 1);
    checkOutput("set_vs_clr_after", len_err, 1);
    pulse_err_clr();
    checkOutput("errclr2", len_err, 0);

    // Read-only scan, then capture winning over shift
    capture();
    run_udr(1'b0, 0, act_s, nact_s, n_pulse, err_s);
    checkOutput("ro_npulse", n_pulse, 0);
    checkOutput("ro_err", len_err, 0);
    checkOutput("ro_jdo", jdo, 38'h00_ABCD_1234);
    vs_cdr = 1'b1;
    vs_sdr = 1'b1;
    wait_neg(4);
    tck_pulse();
    vs_cdr = 1'b0;
    vs_sdr = 1'b0;
    wait_neg(4);
    checkOutput("cdr_sdr_tdo", tdo, SLICE1[0]);
    run_udr(1'b0, 0, act_s, nact_s, n_pulse, err_s);
    checkOutput("cdr_sdr_npulse", n_pulse, 0);
    checkOutput("cdr_sdr_err", len_err, 0);

    // Same-cycle update-IR and update-DR: pulse uses old instruction
    run_uir(2'b00);
    checkOutput("ir0", ir_latched, 0);
    capture();
    applyStimulus(38'h38_0000_00FF, SR_W, stream);
    ir_in = 2'b11;
    wait_neg(4);
    run_udr(1'b1, 0, act_s, nact_s, n_pulse, err_s);
    checkOutput("same_act", act_s, 4'b0001);
    checkOutput("same_npulse", n_pulse, 1);
    checkOutput("same_ir", ir_latched, 3);
    checkOutput("same_jdo", jdo, 38'h38_0000_00FF);
    capture();
    applyStimulus(38'h07_FFFF_0000, SR_W, stream);
    run_udr(1'b0, 0, act_s, nact_s, n_pulse, err_s);
    checkOutput("ir3_nact", nact_s, 4'b1000);
    checkOutput("ir3_act", act_s, 4'b0000);

    // Reset mid-scan discards it
    capture();
    applyStimulus(38'h3F_FFFF_FFFF, 20, stream);
    reset_n = 1'b0;
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(4);
    checkOutput("midrst_jdo", jdo, 0);
    checkOutput("midrst_ir", ir_latched, 0);
    run_udr(1'b0, 0, act_s, nact_s, n_pulse, err_s);
    checkOutput("midrst_npulse", n_pulse, 0);
    checkOutput("midrst_err", len_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_debug_scan_bridge.md
Name: cpu_debug_scan_bridge

Overview:
- Parametrised successor to the CPU JTAG debug module wrapper. Oversamples a virtual-JTAG scan port entirely in the system clock domain, so there is no separate tck domain.
- Holds a generic-width data shift register and per-instruction capture sources. Delivers the shifted word as jdo with one-hot take_action / take_no_action pulses per IR code.
- Adds scan-length checking, which the previous generation lacks. Sits between the sld virtual-JTAG hub and the CPU OCI/trace/break logic.

Parameters:
- SR_W, 38, shift register / jdo width (>=4).
- IR_W, 2, instruction width; NCH = 2**IR_W action channels.
- SYNC_STAGES, 2, synchroniser depth for all scan inputs (>=2).
- ACT_BIT, 35, jdo bit selecting action (1) vs no-action (0); must be < SR_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- tck  in  1  raw JTAG clock, sampled as data.
- tdi  in  1  raw scan data in.
- vs_cdr  in  1  virtual capture-DR state.
- vs_sdr  in  1  virtual shift-DR state.
- vs_udr  in  1  virtual update-DR state.
- vs_uir  in  1  virtual update-IR state.
- ir_in  in  IR_W  virtual instruction.
- capture_data  in  SR_W*NCH  capture word; slice k = [k*SR_W +: SR_W] for IR code k.
- err_clr  in  1  clears len_err.
- tdo  out  1  scan data out.
- jdo  out  SR_W  last accepted update word.
- ir_latched  out  IR_W  instruction latched at update-IR.
- take_action  out  NCH  one-cycle pulse, index = ir_latched.
- take_no_action  out  NCH  one-cycle pulse, index = ir_latched.
- len_err  out  1  sticky scan-length error.

Behaviour:
- Reset (reset_n=0 at a clk edge): all synchroniser flops, edge-history flops, sr, shift count, tdo, jdo, ir_latched, pulses and len_err go to 0. Reset mid-scan discards the scan; no pulse is issued for it.
- Synchronisers: tck, tdi, vs_*, and ir_in each pass through SYNC_STAGES flops. Edge detectors compare each synchronised signal to its one-cycle-delayed copy. tck_rise = tck_s & ~tck_q; uir_rise and udr_rise are defined the same way.
- Shift register, on a clk cycle with tck_rise:
  - if cdr_s: sr <= capture_data slice[ir_s]; cnt <= 0. Capture wins over shift when both are high.
  - else if sdr_s: sr <= {tdi_s, sr[SR_W-1:1]}; cnt <= cnt+1, saturating at SR_W+1.
  - otherwise sr holds.
- tdo <= sr[0] every clk (one-cycle registered).
- uir_rise: ir_latched <= ir_s.
- udr_rise at cycle N, evaluated with cnt and sr as registered at N:
  - cnt == SR_W: jdo <= sr. At N+1, exactly one of take_action[ir_latched] (sr[ACT_BIT]=1) or take_no_action[ir_latched] (sr[ACT_BIT]=0) is high for one cycle.
  - cnt == 0: read-only scan. jdo holds, no pulse, no error.
  - any other cnt: jdo holds, no pulse, len_err <= 1.
  - After any udr_rise, cnt <= 0.
- Same-cycle uir_rise and udr_rise: the pulse uses the old ir_latched.
- len_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
- Latency from a raw input edge to its effect is SYNC_STAGES+1 clks. The tck high and low phases must each last at least SYNC_STAGES+1 clks; faster tck is out of contract and is not detected.
- All pulse outputs are 0 except in the cycle defined above. At most one bit across take_action|take_no_action is high in any cycle.

Test Plan:
- Reset: hold reset_n=0 for 3 clks with tck toggling -> all outputs 0. Release -> jdo=0, len_err=0, no pulses.
- IR=2: uir with ir_in=2'b10. cdr with slice2=38'h0_1234_5678, then 38 sdr shifts of tdi=1 -> tdo stream LSB-first reproduces 0x12345678. udr -> jdo=38'h3F_FFFF_FFFF, take_action=4'b0100 for exactly 1 clk, SYNC_STAGES+1 clks after the raw udr edge.
- ir_latched=1, shift 38 bits with bit35=0 -> take_no_action=4'b0010 pulse, take_action stays 0.
- Shift only 37 bits, then udr -> no pulse, jdo unchanged, len_err=1. err_clr -> 0. Repeat with err_clr asserted in the same cycle as the bad udr -> len_err=1.
- cdr then udr with no shift -> no pulse, len_err=0, jdo unchanged. cdr and sdr both high at one tck edge -> sr loads capture, cnt=0.
- Raw uir and udr edges arriving in the same clk: ir_latched changes from 0 to 3 -> pulse lands on index 0; the next scan pulses index 3. Assert reset_n=0 after 20 shifts -> subsequent udr with 0 shifts gives no pulse.
